// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder controller sharing one 1-bit add cell across WIDTH bits
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_s;
  logic             carry_nx;
  logic [WIDTH-1:0] ps_nx;

  // The single shared add cell: two half adders feeding the carry flop.
  assign bit_s    = sa[0] ^ sb[0] ^ carry;
  assign carry_nx = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));

  generate
    if (WIDTH == 1) begin : g_ps_one
      assign ps_nx = bit_s;
    end else begin : g_ps_wide
      assign ps_nx = {bit_s, ps[WIDTH-1:1]};
    end
  endgenerate

  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sa      <= '0;
      sb      <= '0;
      ps      <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            sa    <= a_in;
            sb    <= b_in;
            carry <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          ps    <= ps_nx;
          carry <= carry_nx;
          if (cnt == LAST_CNT) begin
            sum_out <= ps_nx;
            cout    <= carry_nx;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
